// File: rtl/mdu_seq_if.sv
// Execute-stage <-> multiply/divide sequencer bus: launch/op/operands/mt* toward the sequencer, status and HI/LO back.
// The CPU controller drives the master side; the sequencer is the slave.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] Read_data_1;
    logic [XLEN-1:0] Read_data_2;
    logic            flush;
    logic            mthi;
    logic            mtlo;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output start, op, Read_data_1, Read_data_2, flush, mthi, mtlo,
        input  busy, done, div_zero, HI, LO
    );

    modport slave (
        input  start, op, Read_data_1, Read_data_2, flush, mthi, mtlo,
        output busy, done, div_zero, HI, LO
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; one shared 34-bit add/sub, 32 iterations + 1 sign cycle.
// Latency: start at E0 -> HI/LO and done after E33 (div-by-zero: done after E0); MDU_EARLY_OUT_EN shortens multiplies.
// Backpressure: busy stalls issue; start while busy is dropped, flush aborts CALC/SIGN with HI/LO untouched.
module mdu_seq #(
    parameter int XLEN   = 32,
    parameter int ITER_W = 6
) (
    input  logic       clock,
    input  logic       reset,
    mdu_seq_if.slave   bus
);
    localparam int W = XLEN;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic              neg_res;
    logic              neg_rem;
    logic [W-1:0]      opnd;
    logic [W-1:0]      acc_hi;
    logic [W-1:0]      acc_lo;
    logic [ITER_W-1:0] cnt;
    logic [W-1:0]      hi_q;
    logic [W-1:0]      lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dz_q;

    // Operand capture
    logic         sgn_op;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         start_ok;

    assign sgn_op   = ~bus.op[0];
    assign a_neg    = sgn_op & bus.Read_data_1[W-1];
    assign b_neg    = sgn_op & bus.Read_data_2[W-1];
    assign mag_a    = a_neg ? (~bus.Read_data_1 + 1'b1) : bus.Read_data_1;
    assign mag_b    = b_neg ? (~bus.Read_data_2 + 1'b1) : bus.Read_data_2;
    assign start_ok = bus.start & ~bus.flush;

    // Shared datapath: multiply adds the multiplicand into the upper half, divide trial-subtracts
    // the divisor from the remainder shifted left by one.
    logic         is_div;
    logic         sub;
    logic [W+1:0] add_a;
    logic [W+1:0] add_b;
    logic [W+1:0] add_sum;
    logic [W-1:0] nxt_hi;
    logic [W-1:0] nxt_lo;
    logic         last;
    logic         finish;
    logic         rem_ok;

    assign is_div = op_q[1];
    assign sub    = is_div;
    assign last   = (cnt == ITER_W'(W - 1));

`ifdef MDU_EARLY_OUT_EN
    logic [W-1:0]      rem_mask;
    logic [ITER_W-1:0] out_sh;
    logic [2*W-1:0]    aligned;
    logic              mul_early;
`endif

    always_comb begin
        add_a  = '0;
        add_b  = '0;
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        rem_ok = 1'b0;
        if (is_div) begin
            add_a = {1'b0, acc_hi, acc_lo[W-1]};
            add_b = {2'b00, opnd};
        end else begin
            add_a = {2'b00, acc_hi};
            add_b = acc_lo[0] ? {2'b00, opnd} : '0;
        end
        add_sum = add_a + (add_b ^ {(W+2){sub}}) + {{(W+1){1'b0}}, sub};
        if (is_div) begin
            rem_ok = ~add_sum[W+1];
            nxt_hi = rem_ok ? add_sum[W-1:0] : {acc_hi[W-2:0], acc_lo[W-1]};
            nxt_lo = {acc_lo[W-2:0], rem_ok};
        end else begin
            nxt_hi = add_sum[W:1];
            nxt_lo = {add_sum[0], acc_lo[W-1:1]};
        end
        finish = last;
`ifdef MDU_EARLY_OUT_EN
        // Multiplier bits still to be consumed sit in the low (W-1-cnt) bits of nxt_lo; once they are
        // all zero only shifts remain, so apply them in one step.
        rem_mask  = {W{1'b1}} >> (cnt + ITER_W'(1));
        out_sh    = ITER_W'(W - 1) - cnt;
        aligned   = {nxt_hi, nxt_lo} >> out_sh;
        mul_early = ~is_div & ((nxt_lo & rem_mask) == '0);
        if (mul_early) begin
            nxt_hi = aligned[2*W-1:W];
            nxt_lo = aligned[W-1:0];
            finish = 1'b1;
        end
`endif
    end

    // Sign fix-up
    logic [2*W-1:0] prod_neg;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    always_comb begin
        prod_neg = ~{acc_hi, acc_lo} + 1'b1;
        if (is_div) begin
            res_hi = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
            res_lo = neg_res ? (~acc_lo + 1'b1) : acc_lo;
        end else begin
            res_hi = neg_res ? prod_neg[2*W-1:W] : acc_hi;
            res_lo = neg_res ? prod_neg[W-1:0]   : acc_lo;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        if (bus.op[1] && (bus.Read_data_2 == '0)) begin
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            dz_q    <= 1'b0;
                            op_q    <= bus.op;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            opnd    <= bus.op[1] ? mag_b : mag_a;
                            acc_hi  <= '0;
                            acc_lo  <= bus.op[1] ? mag_a : mag_b;
                            cnt     <= '0;
                            busy_q  <= 1'b1;
                            state   <= CALC;
                        end
                    end else if (!bus.start) begin
                        if (bus.mthi) hi_q <= bus.Read_data_1;
                        if (bus.mtlo) lo_q <= bus.Read_data_1;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + ITER_W'(1);
                        if (finish) state <= SIGN;
                    end
                end
                SIGN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (!bus.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Randomized + directed bench for mdu_seq against an arithmetic reference model of HI/LO, div_zero and latency.
module tb_mdu_seq;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_seq_if #(.XLEN(32)) bus ();

    mdu_seq #(.XLEN(32), .ITER_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] mag;
        int          msb;
        mag = (!o[0] && b[31]) ? (~b + 32'd1) : b;
        msb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
        if (EARLY && !o[1]) return msb + 2;
        return 33;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic [63:0] pu;
        longint      sa, sb, sp, sq, sr;
        logic [63:0] sv;
        logic        edz;
        int          lat, n, bc;
        edz = o[1] && (b == 32'd0);
        eh  = m_hi;
        el  = m_lo;
        sa  = $signed(a);
        sb  = $signed(b);
        if (!edz) begin
            case (o)
                2'b00: begin sp = sa * sb; sv = sp; eh = sv[63:32]; el = sv[31:0]; end
                2'b01: begin pu = {32'd0, a} * {32'd0, b}; eh = pu[63:32]; el = pu[31:0]; end
                2'b10: begin
                    sq = sa / sb; sr = sa % sb;
                    sv = sq; el = sv[31:0];
                    sv = sr; eh = sv[31:0];
                end
                default: begin el = a / b; eh = a % b; end
            endcase
        end
        lat = edz ? 0 : exp_latency(o, b);

        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.Read_data_1 = a; bus.Read_data_2 = b;
        @(negedge clock);
        bus.start = 1'b0;
        check("div_zero_at_start", bus.div_zero, edz);
        n = 0; bc = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) bc++;
            @(negedge clock);
            n++;
        end
        check("done_latency", n, lat);
        check("busy_cycles", bc, lat);
        check("hi", bus.HI, eh);
        check("lo", bus.LO, el);
        check("div_zero", bus.div_zero, edz);
        @(negedge clock);
        check("done_pulse_end", bus.done, 0);
        check("busy_after", bus.busy, 0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_mt(input logic h, input logic l, input logic [31:0] v);
        @(negedge clock);
        bus.mthi = h; bus.mtlo = l; bus.Read_data_1 = v;
        @(negedge clock);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        check("mt_hi", bus.HI, m_hi);
        check("mt_lo", bus.LO, m_lo);
    endtask

    initial begin
        int dcnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.op = 2'b00; bus.Read_data_1 = '0; bus.Read_data_2 = '0;
        bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_hi", bus.HI, 0);
        check("rst_lo", bus.LO, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_zero, 0);
        @(negedge clock);
        reset = 1'b0;

        do_op(2'b00, 32'hFFFFFFFD, 32'd7);
        check("tp_mult_hi", bus.HI, 32'hFFFFFFFF);
        check("tp_mult_lo", bus.LO, 32'hFFFFFFEB);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("tp_multu_hi", bus.HI, 32'hFFFFFFFE);
        check("tp_multu_lo", bus.LO, 32'h00000001);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2);
        check("tp_div_lo", bus.LO, 32'hFFFFFFFD);
        check("tp_div_hi", bus.HI, 32'hFFFFFFFF);
        do_op(2'b11, 32'd100, 32'd7);
        check("tp_divu_lo", bus.LO, 32'd14);
        check("tp_divu_hi", bus.HI, 32'd2);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        check("ovf_div_lo", bus.LO, 32'h80000000);
        check("ovf_div_hi", bus.HI, 32'd0);
        do_op(2'b10, 32'hFFFFFF85, 32'd1);

        // divide by zero with preset HI/LO, then a following start clears the flag
        do_mt(1'b1, 1'b0, 32'h11);
        do_mt(1'b0, 1'b1, 32'h22);
        do_op(2'b11, 32'd5, 32'd0);
        check("dz_hi_kept", bus.HI, 32'h11);
        check("dz_lo_kept", bus.LO, 32'h22);
        do_op(2'b01, 32'd6, 32'd9);
        do_mt(1'b1, 1'b1, 32'h5A5A0001);

        // in-flight mult: stray start ignored, flush aborts without done
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b00; bus.Read_data_1 = 32'h1234; bus.Read_data_2 = 32'h7777;
        dcnt = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clock);
            bus.start = (i == 10);
            bus.Read_data_1 = 32'hDEAD0000 + i;
            bus.flush = (i == 20);
            if (bus.done) dcnt++;
            if (i == 15) check("busy_mid_mult", bus.busy, 1);
            if (i == 21) check("busy_after_flush", bus.busy, 0);
        end
        bus.flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.done) dcnt++;
        end
        check("flush_no_done", dcnt, 0);
        check("flush_hi_kept", bus.HI, m_hi);
        check("flush_lo_kept", bus.LO, m_lo);
        do_mt(1'b0, 1'b1, 32'h0000ABCD);
        check("flush_mtlo", bus.LO, 32'h0000ABCD);

        // randomized ops with occasional mt writes
        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_op(ro, ra, rb);
        end

        // asynchronous reset between clock edges mid-CALC
        do_mt(1'b1, 1'b1, 32'hCAFEF00D);
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b11; bus.Read_data_1 = 32'd1000; bus.Read_data_2 = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_hi", bus.HI, 0);
        check("arst_lo", bus.LO, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_dz", bus.div_zero, 0);
        @(negedge clock);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;

        do_op(2'b00, 32'd3, 32'd1);
        check("mult3x1_lo", bus.LO, 32'd3);
        check("mult3x1_hi", bus.HI, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
